// File: rtl/sequence_lock_pkg.sv
// Shared types for sequence_lock: FSM state encoding, default code/length constants
// and the indicator decode used to register the LED/lockout outputs.
package sequence_lock_pkg;

   typedef enum logic [2:0] {
      S_IDLE,
      S_ENTRY,
      S_CHECK,
      S_FAILURE,
      S_SUCCESS,
      S_LOCKOUT
   } state_t;

   localparam int          DEF_CODE_W         = 4;
   localparam int          DEF_SEQ_LEN        = 3;
   localparam logic [11:0] DEF_SEQ_CODES      = 12'h185;
   localparam int          DEF_MAX_TRIES      = 3;
   localparam int          DEF_LOCKOUT_CYCLES = 16;
   localparam int          DEF_TIMEOUT_CYCLES = 1024;

   typedef struct packed {
      logic r;
      logic g;
      logic b;
      logic lock;
   } ind_t;

   // Indicator pattern shown while the FSM sits in a given state; at most one LED lit.
   function automatic ind_t ind_decode(input state_t s);
      ind_t v;
      v = '0;
      case (s)
         S_ENTRY, S_CHECK: v.b = 1'b1;
         S_FAILURE:        v.r = 1'b1;
         S_SUCCESS:        v.g = 1'b1;
         S_LOCKOUT: begin
            v.r    = 1'b1;
            v.lock = 1'b1;
         end
         default:          v = '0;
      endcase
      return v;
   endfunction

endpackage

// File: rtl/sequence_lock_timer.sv
// lock_timer: loadable down-counter; o_done is high for the single cycle the count reads 1,
// so a load of N makes o_done fire N-1 cycles later and the owner acts on the Nth edge.
module lock_timer #(
   parameter int W = 5
) (
   input  logic         clk,
   input  logic         reset_n,
   input  logic         i_load,
   input  logic [W-1:0] i_load_val,
   output logic         o_done
);

   logic [W-1:0] r_cnt;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_cnt <= '0;
      end else if (i_load) begin
         r_cnt <= i_load_val;
      end else if (r_cnt != '0) begin
         r_cnt <= r_cnt - 1'b1;
      end
   end

   assign o_done = (r_cnt == W'(1));

endmodule

// File: rtl/sequence_lock.sv
// sequence_lock: code-sequence lock FSM with failure counting and timed lockout; Moore outputs,
// one cycle after the causing action_in. Optional entry timeout under SEQUENCE_LOCK_TIMEOUT_EN.
module sequence_lock
   import sequence_lock_pkg::*;
#(
   parameter int                            CODE_W         = DEF_CODE_W,
   parameter int                            SEQ_LEN        = DEF_SEQ_LEN,
   parameter logic [SEQ_LEN*CODE_W-1:0]     SEQ_CODES      = DEF_SEQ_CODES,
   parameter int                            MAX_TRIES      = DEF_MAX_TRIES,
   parameter int                            LOCKOUT_CYCLES = DEF_LOCKOUT_CYCLES,
   parameter int                            TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
   input  logic                             clk,
   input  logic                             reset_n,
   input  logic                             action_in,
   input  logic [CODE_W-1:0]                code_in,
   output logic                             led_r_out,
   output logic                             led_g_out,
   output logic                             led_b_out,
   output logic                             locked_out,
   output logic [$clog2(MAX_TRIES+1)-1:0]   fail_count_out,
   output logic [$clog2(SEQ_LEN+1)-1:0]     entry_idx_out
);

   localparam int FW      = $clog2(MAX_TRIES + 1);
   localparam int IW      = $clog2(SEQ_LEN + 1);
   localparam int TMR_MAX = (LOCKOUT_CYCLES > TIMEOUT_CYCLES) ? LOCKOUT_CYCLES : TIMEOUT_CYCLES;
   localparam int TW      = $clog2(TMR_MAX + 1);

   state_t            r_state;
   logic [IW-1:0]     r_idx;
   logic [FW-1:0]     r_fail;
   logic              r_mis;
   ind_t              r_ind;

   logic [CODE_W-1:0] w_codes [SEQ_LEN];
   logic [CODE_W-1:0] w_exp;
   logic              w_last;
   logic [FW-1:0]     w_fail_inc;
   logic              w_tmr_load;
   logic [TW-1:0]     w_tmr_val;
   logic              w_tmr_done;

   for (genvar k = 0; k < SEQ_LEN; k++) begin : g_codes
      assign w_codes[k] = SEQ_CODES[k*CODE_W +: CODE_W];
   end

   assign w_exp      = w_codes[r_idx];
   assign w_last     = (r_idx == IW'(SEQ_LEN - 1));
   assign w_fail_inc = r_fail + 1'b1;

   // CHECK always arms the lockout duration; it only matters if LOCKOUT follows.
`ifdef SEQUENCE_LOCK_TIMEOUT_EN
   assign w_tmr_load = (r_state == S_CHECK) ||
                       (action_in && ((r_state == S_IDLE) || (r_state == S_ENTRY)));
   assign w_tmr_val  = (r_state == S_CHECK) ? TW'(LOCKOUT_CYCLES) : TW'(TIMEOUT_CYCLES);
`else
   assign w_tmr_load = (r_state == S_CHECK);
   assign w_tmr_val  = TW'(LOCKOUT_CYCLES);
`endif

   lock_timer #(.W(TW)) u_timer (
      .clk        (clk),
      .reset_n    (reset_n),
      .i_load     (w_tmr_load),
      .i_load_val (w_tmr_val),
      .o_done     (w_tmr_done)
   );

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state <= S_IDLE;
         r_idx   <= '0;
         r_fail  <= '0;
         r_mis   <= 1'b0;
         r_ind   <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (action_in) begin
                  r_state <= S_ENTRY;
                  r_ind   <= ind_decode(S_ENTRY);
                  r_idx   <= '0;
                  r_mis   <= 1'b0;
               end
            end
            S_ENTRY: begin
               // Entry always runs to full length so a wrong code leaks no position info.
               if (action_in) begin
                  r_mis <= r_mis | (code_in != w_exp);
                  r_idx <= r_idx + 1'b1;
                  if (w_last) begin
                     r_state <= S_CHECK;
                     r_ind   <= ind_decode(S_CHECK);
                  end
               end
`ifdef SEQUENCE_LOCK_TIMEOUT_EN
               else if (w_tmr_done) begin
                  r_mis   <= 1'b1;
                  r_state <= S_CHECK;
                  r_ind   <= ind_decode(S_CHECK);
               end
`endif
            end
            S_CHECK: begin
               r_idx <= '0;
               if (r_mis) begin
                  r_fail <= w_fail_inc;
                  if (w_fail_inc == FW'(MAX_TRIES)) begin
                     r_state <= S_LOCKOUT;
                     r_ind   <= ind_decode(S_LOCKOUT);
                  end else begin
                     r_state <= S_FAILURE;
                     r_ind   <= ind_decode(S_FAILURE);
                  end
               end else begin
                  r_fail  <= '0;
                  r_state <= S_SUCCESS;
                  r_ind   <= ind_decode(S_SUCCESS);
               end
            end
            S_FAILURE, S_SUCCESS: begin
               if (action_in) begin
                  r_state <= S_IDLE;
                  r_ind   <= ind_decode(S_IDLE);
               end
            end
            S_LOCKOUT: begin
               if (w_tmr_done) begin
                  r_state <= S_IDLE;
                  r_ind   <= ind_decode(S_IDLE);
                  r_fail  <= '0;
               end
            end
            default: begin
               r_state <= S_IDLE;
               r_ind   <= '0;
               r_idx   <= '0;
            end
         endcase
      end
   end

   assign led_r_out      = r_ind.r;
   assign led_g_out      = r_ind.g;
   assign led_b_out      = r_ind.b;
   assign locked_out     = r_ind.lock;
   assign fail_count_out = r_fail;
   assign entry_idx_out  = r_idx;

endmodule

// File: tb/tb_sequence_lock.sv
// Bench for sequence_lock: directed scenarios plus random traffic, every cycle compared against
// a phase/queue reference model. Timeout scenario active when SEQUENCE_LOCK_TIMEOUT_EN is defined.
module tb_sequence_lock;

   localparam int TO_C   = 8;
   localparam int LOCK_C = 16;
   localparam int MAXT   = 3;
   localparam int SEQ    = 3;

   localparam int P_IDLE  = 0;
   localparam int P_ENTRY = 1;
   localparam int P_CHECK = 2;
   localparam int P_FAIL  = 3;
   localparam int P_OK    = 4;
   localparam int P_LOCK  = 5;

   logic       clk = 1'b0;
   logic       reset_n;
   logic       action_in;
   logic [3:0] code_in;
   logic       led_r_out, led_g_out, led_b_out, locked_out;
   logic [1:0] fail_count_out;
   logic [1:0] entry_idx_out;

   sequence_lock #(
      .CODE_W(4), .SEQ_LEN(SEQ), .SEQ_CODES(12'h185), .MAX_TRIES(MAXT),
      .LOCKOUT_CYCLES(LOCK_C), .TIMEOUT_CYCLES(TO_C)
   ) dut (
      .clk(clk), .reset_n(reset_n), .action_in(action_in), .code_in(code_in),
      .led_r_out(led_r_out), .led_g_out(led_g_out), .led_b_out(led_b_out),
      .locked_out(locked_out), .fail_count_out(fail_count_out), .entry_idx_out(entry_idx_out)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_mis = 0;

   int m_phase, m_fail, m_left, m_idle;
   bit m_to;
   int m_q[$];
   int exp_code[3] = '{5, 8, 1};

   task automatic chk(input string tag, input logic [31:0] obs, input int exp);
      n_cmp++;
      if (obs !== 32'(exp)) begin
         n_mis++;
         $display("FAIL %s: got %0d, expected %0d at %0t", tag, obs, exp, $time);
      end
   endtask

   function automatic void m_reset();
      m_phase = P_IDLE;
      m_fail  = 0;
      m_left  = 0;
      m_idle  = 0;
      m_to    = 1'b0;
      m_q.delete();
   endfunction

   function automatic void m_step(input bit act, input int code);
      bit ok;
      case (m_phase)
         P_IDLE: if (act) begin
            m_phase = P_ENTRY;
            m_q.delete();
            m_idle = 0;
            m_to   = 1'b0;
         end
         P_ENTRY: begin
            if (act) begin
               m_q.push_back(code);
               m_idle = 0;
               if (m_q.size() == SEQ) m_phase = P_CHECK;
            end else begin
               m_idle++;
`ifdef SEQUENCE_LOCK_TIMEOUT_EN
               if (m_idle == TO_C) begin
                  m_to    = 1'b1;
                  m_phase = P_CHECK;
               end
`endif
            end
         end
         P_CHECK: begin
            ok = !m_to && (m_q.size() == SEQ);
            for (int k = 0; k < m_q.size(); k++)
               if (m_q[k] != exp_code[k]) ok = 1'b0;
            if (ok) begin
               m_phase = P_OK;
               m_fail  = 0;
            end else begin
               m_fail++;
               if (m_fail == MAXT) begin
                  m_phase = P_LOCK;
                  m_left  = LOCK_C;
               end else begin
                  m_phase = P_FAIL;
               end
            end
         end
         P_FAIL, P_OK: if (act) m_phase = P_IDLE;
         P_LOCK: begin
            m_left--;
            if (m_left == 0) begin
               m_phase = P_IDLE;
               m_fail  = 0;
            end
         end
         default: m_phase = P_IDLE;
      endcase
   endfunction

   task automatic check_outs();
      chk("led_r", led_r_out, (m_phase == P_FAIL || m_phase == P_LOCK) ? 1 : 0);
      chk("led_g", led_g_out, (m_phase == P_OK) ? 1 : 0);
      chk("led_b", led_b_out, (m_phase == P_ENTRY || m_phase == P_CHECK) ? 1 : 0);
      chk("locked", locked_out, (m_phase == P_LOCK) ? 1 : 0);
      chk("fail_count", fail_count_out, m_fail);
      chk("entry_idx", entry_idx_out,
          (m_phase == P_ENTRY || m_phase == P_CHECK) ? m_q.size() : 0);
      chk("one_led", ($countones({led_r_out, led_g_out, led_b_out}) <= 1) ? 1 : 0, 1);
   endtask

   task automatic cycle(input bit act, input int code);
      action_in = act;
      code_in   = 4'(code);
      @(posedge clk);
      m_step(act, code);
      #1;
      check_outs();
   endtask

   task automatic attempt(input int c0, input int c1, input int c2);
      cycle(1'b1, 0);
      cycle(1'b1, c0);
      cycle(1'b1, c1);
      cycle(1'b1, c2);
      cycle(1'b0, 0);
   endtask

   // Called at posedge+1; asserts reset mid-cycle so the async clear is observed before any edge.
   task automatic do_reset();
      #3 reset_n = 1'b0;
      #1 m_reset();
      check_outs();
      action_in = 1'b1;
      code_in   = 4'd5;
      @(posedge clk);
      #1 check_outs();
      @(negedge clk);
      reset_n   = 1'b1;
      action_in = 1'b0;
      @(posedge clk);
      m_step(1'b0, 0);
      #1 check_outs();
   endtask

   initial begin
      int n_lock;
      reset_n   = 1'b0;
      action_in = 1'b0;
      code_in   = '0;
      m_reset();
      #1 check_outs();
      repeat (2) @(posedge clk);
      #1 check_outs();
      @(negedge clk);
      reset_n = 1'b1;
      cycle(1'b0, 0);

      // Correct sequence
      attempt(5, 8, 1);
      chk("ok_led_g", led_g_out, 1);
      chk("ok_fail", fail_count_out, 0);
      cycle(1'b1, 0);
      chk("ok_back_idle", {led_r_out, led_g_out, led_b_out}, 0);

      // Wrong middle code: entry continues to the third code
      cycle(1'b1, 0);
      cycle(1'b1, 5);
      cycle(1'b1, 15);
      chk("wrong_still_entry", led_b_out, 1);
      chk("wrong_idx2", entry_idx_out, 2);
      cycle(1'b1, 1);
      cycle(1'b0, 0);
      chk("wrong_led_r", led_r_out, 1);
      chk("wrong_fail1", fail_count_out, 1);
      cycle(1'b1, 0);

      // Two more failures -> lockout, actions ignored throughout
      attempt(5, 15, 1);
      cycle(1'b1, 0);
      attempt(0, 0, 0);
      chk("lock_enter", locked_out, 1);
      n_lock = 1;
      for (int i = 0; i < 40; i++) begin
         cycle(1'b1, $urandom_range(0, 15));
         if (locked_out) n_lock++;
         else break;
      end
      chk("lock_len", n_lock, LOCK_C);
      chk("lock_exit_fail0", fail_count_out, 0);
      chk("lock_exit_idle", led_b_out, 0);

      // Two failures then success clears the count
      attempt(1, 1, 1);
      cycle(1'b1, 0);
      attempt(1, 1, 1);
      chk("two_fail", fail_count_out, 2);
      cycle(1'b1, 0);
      attempt(5, 8, 1);
      chk("recover_g", led_g_out, 1);
      chk("recover_fail0", fail_count_out, 0);
      cycle(1'b1, 0);

`ifdef SEQUENCE_LOCK_TIMEOUT_EN
      cycle(1'b1, 0);
      cycle(1'b1, 5);
      repeat (TO_C) cycle(1'b0, 0);
      chk("to_check", led_b_out, 1);
      cycle(1'b0, 0);
      chk("to_led_r", led_r_out, 1);
      chk("to_fail1", fail_count_out, 1);
      cycle(1'b1, 0);
`endif

      // Reset after the second code
      cycle(1'b1, 0);
      cycle(1'b1, 5);
      cycle(1'b1, 8);
      do_reset();
      cycle(1'b1, 0);
      chk("post_rst_entry", led_b_out, 1);
      cycle(1'b1, 5);
      cycle(1'b1, 8);
      cycle(1'b1, 1);
      cycle(1'b0, 0);
      chk("post_rst_ok", led_g_out, 1);
      cycle(1'b1, 0);

      // Reset mid-lockout
      attempt(0, 0, 0);
      cycle(1'b1, 0);
      attempt(0, 0, 0);
      cycle(1'b1, 0);
      attempt(0, 0, 0);
      repeat (5) cycle(1'b1, 0);
      chk("mid_lock", locked_out, 1);
      do_reset();
      chk("rst_lock_clear", locked_out, 0);
      chk("rst_lock_fail0", fail_count_out, 0);

      // Random traffic
      for (int i = 0; i < 3000; i++) begin
         bit a;
         int c;
         a = ($urandom_range(0, 2) != 0);
         if (m_phase == P_ENTRY && m_q.size() < SEQ && $urandom_range(0, 3) != 0)
            c = exp_code[m_q.size()];
         else
            c = $urandom_range(0, 15);
         if ($urandom_range(0, 499) == 0) do_reset();
         else cycle(a, c);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule
